// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Owner encoding, byte-enable width and the default loader starvation limit.
// Imported by dmem_arbiter and arb_starve_ctr.
package mem_arb_pkg;

    // Which master owned a memory slot
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } owner_e;

    localparam int BE_W           = 4;
    localparam int STARVE_LIM_DEF = 4;

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Loader grant decision plus the starvation counter that bounds loader wait.
// Latency: grant is combinational in the request cycle; counter updates on CLK.
// Backpressure: a loader request that is not granted simply counts up until forced.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic CLK,
    input  logic rst,
    input  logic cpu_req,
    input  logic ldr_req,
    input  logic ldr_lock,
    output logic gnt_ldr
);

    localparam logic [3:0] LIM_M1 = 4'(STARVE_LIM - 1);

    logic [3:0] starve_cnt;

    // Loader wins when locked, when the CPU is idle, or when it has waited long enough.
    // Held low in reset so nothing is granted while the system is coming up.
    assign gnt_ldr = ~rst & ldr_req & (ldr_lock | ~cpu_req | (starve_cnt == LIM_M1));

    // Count consecutive denied loader cycles, saturating at the forcing threshold
    always_ff @(posedge CLK) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (~ldr_req | gnt_ldr) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIM_M1) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single mem_array data port between the MIPS core and a loader master.
// Latency: grant/mux combinational; read data returns one cycle after the granted read.
// Backpressure: CPU gets cpu_stall for every lost slot; loader retries until ldr_gnt.
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            cpu_req,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [BE_W-1:0] cpu_wr_en,
    input  logic [DW-1:0]   cpu_wdata,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_stall,
    input  logic            ldr_req,
    input  logic            ldr_lock,
    input  logic [AW-1:0]   ldr_addr,
    input  logic [BE_W-1:0] ldr_wr_en,
    input  logic [DW-1:0]   ldr_wdata,
    output logic            ldr_gnt,
    output logic [DW-1:0]   ldr_rdata,
    output logic            ldr_rvalid,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    output logic [BE_W-1:0] mem_wren,
    input  logic [DW-1:0]   mem_dout
);

    logic   gnt_ldr;
    logic   cpu_own;
    logic   slot_rd;
    owner_e slot_owner;

    logic   rd_pend_q;
    owner_e rd_owner_q;
    logic [DW-1:0] cpu_rdata_q;

    arb_starve_ctr #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .CLK      (CLK),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .ldr_req  (ldr_req),
        .ldr_lock (ldr_lock),
        .gnt_ldr  (gnt_ldr)
    );

    assign cpu_own    = cpu_req & ~gnt_ldr & ~rst;
    assign slot_owner = gnt_ldr ? OWN_LDR : OWN_CPU;
    assign slot_rd    = (gnt_ldr & (ldr_wr_en == '0)) | (cpu_own & (cpu_wr_en == '0));

    assign ldr_gnt   = gnt_ldr;
    assign cpu_stall = cpu_req & gnt_ldr;

    // Owner drives the port; an idle slot parks on the CPU address with writes off
    assign mem_addr = gnt_ldr ? ldr_addr  : cpu_addr;
    assign mem_din  = gnt_ldr ? ldr_wdata : cpu_wdata;
    assign mem_wren = gnt_ldr ? ldr_wr_en : (cpu_own ? cpu_wr_en : '0);

    // Remember who owned each slot and whether it was a read, to steer the return
    always_ff @(posedge CLK) begin
        if (rst) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CPU;
        end else begin
            rd_pend_q  <= slot_rd;
            rd_owner_q <= slot_owner;
        end
    end

    // Keep the last CPU read word so a loader slot never leaks into cpu_rdata
    always_ff @(posedge CLK) begin
        if (rst) begin
            cpu_rdata_q <= '0;
        end else if (rd_pend_q && (rd_owner_q == OWN_CPU)) begin
            cpu_rdata_q <= mem_dout;
        end
    end

    assign ldr_rdata  = mem_dout;
    assign ldr_rvalid = ~rst & rd_pend_q & (rd_owner_q == OWN_LDR);
    assign cpu_rdata  = rst ? '0 : ((rd_owner_q == OWN_LDR) ? cpu_rdata_q : mem_dout);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded bench for dmem_arbiter with a behavioural memory behind mem_*.
// Stimulus drives one slot per cycle and pushes expected grants and read returns.
// A negedge monitor pops and compares whatever the DUT presents.
module tb_dmem_arbiter;

    localparam int LIM = 4;

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } dexp_t;

    typedef struct {
        int          cyc;
        logic        g;
        logic        s;
        logic [3:0]  we;
    } gexp_t;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [3:0]  cpu_wr_en = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ldr_req = 1'b0;
    logic        ldr_lock = 1'b0;
    logic [31:0] ldr_addr = '0;
    logic [3:0]  ldr_wr_en = '0;
    logic [31:0] ldr_wdata = '0;
    logic        ldr_gnt;
    logic [31:0] ldr_rdata;
    logic        ldr_rvalid;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_wren;
    logic [31:0] mem_dout = '0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.STARVE_LIM(LIM), .AW(32), .DW(32)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ldr_req    (ldr_req),
        .ldr_lock   (ldr_lock),
        .ldr_addr   (ldr_addr),
        .ldr_wr_en  (ldr_wr_en),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rdata  (ldr_rdata),
        .ldr_rvalid (ldr_rvalid),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_wren   (mem_wren),
        .mem_dout   (mem_dout)
    );

    // mem_array stand-in: synchronous read, byte-enabled write
    logic [31:0] mem [0:2047];
    always @(posedge CLK) begin
        mem_dout <= mem[mem_addr[12:2]];
        for (int b = 0; b < 4; b++)
            if (mem_wren[b]) mem[mem_addr[12:2]][8*b +: 8] = mem_din[8*b +: 8];
    end

    // Reference model state
    logic [31:0] ref_mem [0:2047];
    int          ldr_wait = 0;
    logic [31:0] last_cpu = '0;
    logic        last_g = 1'b0;
    logic        last_s = 1'b0;
    logic        last_r = 1'b1;

    gexp_t gnt_q[$];
    dexp_t ldr_q[$];
    dexp_t cpu_q[$];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        for (int b = 0; b < 4; b++)
            if (we[b]) ref_mem[a[12:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    // Drive one slot and record what the arbiter should do with it
    task automatic step(input logic r,
                        input logic creq, input logic [31:0] caddr, input logic [3:0] cwe, input logic [31:0] cwd,
                        input logic lreq, input logic llock, input logic [31:0] laddr, input logic [3:0] lwe,
                        input logic [31:0] lwd);
        int   waited;
        logic g, s;
        logic [3:0] we;
        @(posedge CLK);
        #1;
        rst = r;
        cpu_req = creq; cpu_addr = caddr; cpu_wr_en = cwe; cpu_wdata = cwd;
        ldr_req = lreq; ldr_lock = llock; ldr_addr = laddr; ldr_wr_en = lwe; ldr_wdata = lwd;
        g = 1'b0; s = 1'b0; we = 4'h0;
        if (r) begin
            while (ldr_q.size() > 0 && ldr_q[$].cyc == cyc) void'(ldr_q.pop_back());
            while (cpu_q.size() > 0 && cpu_q[$].cyc == cyc) void'(cpu_q.pop_back());
            cpu_q.push_back('{cyc, 32'h0});
            ldr_wait = 0;
            last_cpu = '0;
        end else begin
            waited = ldr_wait + 1;
            g = lreq && (llock || !creq || waited >= LIM);
            ldr_wait = (lreq && !g) ? waited : 0;
            s = creq && g;
            if (g) begin
                we = lwe;
                if (lwe == 4'h0) ldr_q.push_back('{cyc + 1, ref_mem[laddr[12:2]]});
                else ref_write(laddr, lwe, lwd);
                cpu_q.push_back('{cyc + 1, last_cpu});
            end else if (creq) begin
                we = cwe;
                if (cwe == 4'h0) begin
                    last_cpu = ref_mem[caddr[12:2]];
                    cpu_q.push_back('{cyc + 1, last_cpu});
                end else begin
                    ref_write(caddr, cwe, cwd);
                end
            end
        end
        gnt_q.push_back('{cyc, g, s, we});
        last_g = g; last_s = s; last_r = r;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Continuous CPU reads against a continuous loader: forced slot every LIM cycles
    task automatic load_run(input int n);
        logic [31:0] ca;
        bit          exp_g;
        ca = 32'h60;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && !last_s) ca = (ca + 32'h4) & 32'h7C;
            step(1'b0, 1'b1, ca, 4'h0, 32'h0, 1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
            @(negedge CLK);
            exp_g = (i % LIM) == (LIM - 1);
            check("starve_slot", (ldr_gnt === exp_g) && (cpu_stall === exp_g),
                  {62'h0, ldr_gnt, cpu_stall}, {62'h0, exp_g, exp_g});
        end
    endtask

    // Monitor: compare grant, loader return and CPU return against the scoreboard
    gexp_t ge;
    dexp_t de;
    bit    exp_l;
    always @(negedge CLK) begin
        if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
            ge = gnt_q.pop_front();
            check("grant", (ldr_gnt === ge.g) && (cpu_stall === ge.s) && (mem_wren === ge.we),
                  {58'h0, ldr_gnt, cpu_stall, mem_wren}, {58'h0, ge.g, ge.s, ge.we});
        end
        exp_l = (ldr_q.size() > 0) && (ldr_q[0].cyc == cyc);
        if (exp_l || ldr_rvalid) begin
            de = exp_l ? ldr_q.pop_front() : '{cyc, 32'h0};
            check("ldr_return", exp_l && (ldr_rvalid === 1'b1) && (ldr_rdata === de.d),
                  {31'h0, ldr_rvalid, ldr_rdata}, {31'h0, exp_l, de.d});
        end
        if (cpu_q.size() > 0 && cpu_q[0].cyc == cyc) begin
            de = cpu_q.pop_front();
            check("cpu_rdata", cpu_rdata === de.d, {32'h0, cpu_rdata}, {32'h0, de.d});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ca, cwd, la, lwd;
        logic [3:0]  cwe, lwe;
        logic        creq, lreq, llock, r;

        for (int i = 0; i < 2048; i++) begin
            mem[i]     = 32'hA5000000 ^ (i * 32'h00010203);
            ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
        end
        mem[8]  = 32'h11111111; ref_mem[8]  = 32'h11111111;
        mem[12] = 32'h22222222; ref_mem[12] = 32'h22222222;

        // Reset with both masters trying to write/read: nothing may reach memory
        repeat (3) step(1'b1, 1'b1, 32'h10, 4'hF, 32'h55555555, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);

        // CPU-only reads
        step(1'b0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step(1'b0, 1'b1, 32'h14, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        idle();

        // Loader write then read back with CPU idle
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h40, 4'hF, 32'hDEADBEEF);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        idle();
        idle();

        // Starvation pattern under continuous CPU load
        load_run(12);
        idle();

        // CPU read then loader read: cpu_rdata must not show loader data
        step(1'b0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
        idle();

        // Lock: loader owns every cycle, then CPU wins once lock drops
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 32'h24, 4'h0, 32'h0, 1'b1, 1'b1, 32'h48 + 32'(4 * i), 4'h0, 32'h0);
            @(negedge CLK);
            check("lock_slot", (ldr_gnt === 1'b1) && (cpu_stall === 1'b1),
                  {62'h0, ldr_gnt, cpu_stall}, 64'h3);
        end
        step(1'b0, 1'b1, 32'h24, 4'h0, 32'h0, 1'b1, 1'b0, 32'h5C, 4'h0, 32'h0);
        @(negedge CLK);
        check("lock_release", (ldr_gnt === 1'b0) && (cpu_stall === 1'b0),
              {62'h0, ldr_gnt, cpu_stall}, 64'h0);
        idle();

        // Reset lands on a pending loader read; counter restarts afterwards
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        step(1'b1, 1'b1, 32'h18, 4'hF, 32'h12345678, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        step(1'b1, 1'b1, 32'h18, 4'hF, 32'h12345678, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        load_run(8);
        idle();

        // Random traffic; masters re-present anything not served
        creq = 0; lreq = 0; llock = 0;
        ca = 0; cwe = 0; cwd = 0; la = 0; lwe = 0; lwd = 0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) == 0);
            if (!(creq && (last_s || last_r))) begin
                creq = ($urandom_range(0, 3) != 0);
                ca   = 32'($urandom_range(0, 31)) << 2;
                cwe  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                cwd  = $urandom;
            end
            if (!(lreq && !last_g)) begin
                lreq = ($urandom_range(0, 2) == 0);
                la   = 32'($urandom_range(0, 31)) << 2;
                lwe  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                lwd  = $urandom;
            end
            llock = ($urandom_range(0, 15) == 0);
            step(r, creq, ca, cwe, cwd, lreq, llock, la, lwe, lwd);
        end

        repeat (3) idle();
        @(negedge CLK);
        @(negedge CLK);
        check("drain_grant", gnt_q.size() == 0, 64'(gnt_q.size()), 64'h0);
        check("drain_ldr",   ldr_q.size() == 0, 64'(ldr_q.size()), 64'h0);
        check("drain_cpu",   cpu_q.size() == 0, 64'(cpu_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
